// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: EX/MA destination tracking, registered EX forward selects, load-use and mul/div stalls.
// Define HAZARD_FWD_EN to enable forwarding; otherwise any in-flight producer stalls until it reaches WB.
module hazard_ctl #(
   parameter int MD_LAT          = 32,
   parameter int MUX_FWD_RF_NBIT = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       id_valid,
   input  logic [4:0]                 id_rs,
   input  logic [4:0]                 id_rt,
   input  logic                       id_use_rs,
   input  logic                       id_use_rt,
   input  logic [4:0]                 id_wreg,
   input  logic                       id_wen,
   input  logic                       id_is_load,
   input  logic                       id_is_md,
   input  logic                       id_md_read,
   input  logic                       ex_flush,
   output logic                       stall_if_id,
   output logic                       bubble_ex,
   output logic [MUX_FWD_RF_NBIT-1:0] mux_fwd_rf_a,
   output logic [MUX_FWD_RF_NBIT-1:0] mux_fwd_rf_b,
   output logic                       md_busy
);

   localparam int CW = $clog2(MD_LAT + 1);
   localparam logic [CW-1:0] MD_INIT = CW'(MD_LAT);
   localparam logic [MUX_FWD_RF_NBIT-1:0] MUX_FWD_RF_NORM = MUX_FWD_RF_NBIT'(0);

   // A producer already in WB is covered by the register file write-through, so only EX and MA are tracked.
   logic          ex_v, ex_wen, ex_ld;
   logic [4:0]    ex_wreg;
   logic          ma_v, ma_wen;
   logic [4:0]    ma_wreg;
   logic [CW-1:0] md_cnt;

   logic hz_en, issue;
   logic ex_hit_rs, ex_hit_rt, ma_hit_rs, ma_hit_rt;
   logic data_stall, md_stall;

   assign hz_en = id_valid & ~ex_flush;

   assign ex_hit_rs = ex_v & ex_wen & (ex_wreg == id_rs) & (id_rs != 5'd0) & id_use_rs;
   assign ex_hit_rt = ex_v & ex_wen & (ex_wreg == id_rt) & (id_rt != 5'd0) & id_use_rt;
   assign ma_hit_rs = ma_v & ma_wen & (ma_wreg == id_rs) & (id_rs != 5'd0) & id_use_rs;
   assign ma_hit_rt = ma_v & ma_wen & (ma_wreg == id_rt) & (id_rt != 5'd0) & id_use_rt;

   assign md_busy  = (md_cnt != '0);
   assign md_stall = hz_en & md_busy & (id_is_md | id_md_read);

`ifdef HAZARD_FWD_EN
   localparam logic [MUX_FWD_RF_NBIT-1:0] MUX_FWD_RF_TMP = MUX_FWD_RF_NBIT'(1);
   localparam logic [MUX_FWD_RF_NBIT-1:0] MUX_FWD_RF_DAT = MUX_FWD_RF_NBIT'(2);

   assign data_stall = hz_en & ex_ld & (ex_hit_rs | ex_hit_rt);

   function automatic logic [MUX_FWD_RF_NBIT-1:0] fwd_sel(input logic ex_hit, input logic ma_hit);
      if (ex_hit)
         return MUX_FWD_RF_TMP;
      else if (ma_hit)
         return MUX_FWD_RF_DAT;
      else
         return MUX_FWD_RF_NORM;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         mux_fwd_rf_a <= MUX_FWD_RF_NORM;
         mux_fwd_rf_b <= MUX_FWD_RF_NORM;
      end else if (issue) begin
         mux_fwd_rf_a <= fwd_sel(ex_hit_rs, ma_hit_rs);
         mux_fwd_rf_b <= fwd_sel(ex_hit_rt, ma_hit_rt);
      end else begin
         mux_fwd_rf_a <= MUX_FWD_RF_NORM;
         mux_fwd_rf_b <= MUX_FWD_RF_NORM;
      end
   end
`else
   logic [1:0] unused_ld;

   // Without forwarding a load is no different from any other producer.
   assign unused_ld    = {id_is_load, ex_ld};
   assign data_stall   = hz_en & (ex_hit_rs | ex_hit_rt | ma_hit_rs | ma_hit_rt);
   assign mux_fwd_rf_a = MUX_FWD_RF_NORM;
   assign mux_fwd_rf_b = MUX_FWD_RF_NORM;
`endif

   assign stall_if_id = data_stall | md_stall;
   assign bubble_ex   = stall_if_id;
   assign issue       = hz_en & ~stall_if_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_v    <= 1'b0;
         ex_wen  <= 1'b0;
         ex_ld   <= 1'b0;
         ex_wreg <= '0;
         ma_v    <= 1'b0;
         ma_wen  <= 1'b0;
         ma_wreg <= '0;
      end else begin
         ma_v    <= ex_v;
         ma_wen  <= ex_wen;
         ma_wreg <= ex_wreg;
         ex_v    <= issue;
         ex_wen  <= issue & id_wen;
         ex_ld   <= issue & id_is_load;
         ex_wreg <= issue ? id_wreg : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         md_cnt <= '0;
      else if (issue & id_is_md)
         md_cnt <= MD_INIT;
      else if (md_cnt != '0)
         md_cnt <= md_cnt - CW'(1);
   end

endmodule

// File: tb/tb_hazard_ctl.sv
// Table-driven bench for hazard_ctl with a scoreboard queue for the registered forward selects.
// Expectations follow whichever build is compiled (HAZARD_FWD_EN defined or not).
module tb_hazard_ctl;

   localparam int MD_LAT = 4;

   localparam logic [1:0] NRM = 2'd0;
   localparam logic [1:0] TMP = 2'd1;
   localparam logic [1:0] DAT = 2'd2;

   localparam logic [8:0] F_RST = 9'h100;
   localparam logic [8:0] F_V   = 9'h080;
   localparam logic [8:0] F_URS = 9'h040;
   localparam logic [8:0] F_URT = 9'h020;
   localparam logic [8:0] F_WEN = 9'h010;
   localparam logic [8:0] F_LD  = 9'h008;
   localparam logic [8:0] F_MD  = 9'h004;
   localparam logic [8:0] F_MDR = 9'h002;
   localparam logic [8:0] F_FL  = 9'h001;

   localparam logic [8:0] ALU  = F_V | F_URS | F_URT | F_WEN;
   localparam logic [8:0] RD2  = F_V | F_URS | F_URT;
   localparam logic [8:0] WR   = F_V | F_WEN;
   localparam logic [8:0] LW   = F_V | F_WEN | F_LD;
   localparam logic [8:0] MULT = F_V | F_MD | F_URS | F_URT;
   localparam logic [8:0] MFLO = F_V | F_MDR | F_WEN;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_wreg = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wen = 1'b0;
   logic       id_is_load = 1'b0, id_is_md = 1'b0, id_md_read = 1'b0, ex_flush = 1'b0;
   logic       stall_if_id, bubble_ex, md_busy;
   logic [1:0] mux_fwd_rf_a, mux_fwd_rf_b;

   hazard_ctl #(.MD_LAT(MD_LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_wreg      (id_wreg),
      .id_wen       (id_wen),
      .id_is_load   (id_is_load),
      .id_is_md     (id_is_md),
      .id_md_read   (id_md_read),
      .ex_flush     (ex_flush),
      .stall_if_id  (stall_if_id),
      .bubble_ex    (bubble_ex),
      .mux_fwd_rf_a (mux_fwd_rf_a),
      .mux_fwd_rf_b (mux_fwd_rf_b),
      .md_busy      (md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [8:0] f;
      logic [4:0] rs, rt, wreg;
      logic       e_stall, e_busy;
      logic [1:0] e_a, e_b;
   } vec_t;

   typedef struct {
      string      name;
      int         idx;
      logic [1:0] a, b;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic v(input string name, input logic [8:0] f, input int rs, input int rt, input int wreg,
                    input logic es, input logic eb, input logic [1:0] ea, input logic [1:0] ebs);
      vec_t r;
      r.name = name; r.f = f; r.rs = 5'(rs); r.rt = 5'(rt); r.wreg = 5'(wreg);
      r.e_stall = es; r.e_busy = eb; r.e_a = ea; r.e_b = ebs;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input int idx, input string what, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] %s: got %0d, expected %0d", name, idx, what, act, exp);
      end
   endtask

   task automatic drive(input logic [8:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wreg);
      rst = f[8]; id_valid = f[7]; id_use_rs = f[6]; id_use_rt = f[5]; id_wen = f[4];
      id_is_load = f[3]; id_is_md = f[2]; id_md_read = f[1]; ex_flush = f[0];
      id_rs = rs; id_rt = rt; id_wreg = wreg;
   endtask

   initial begin
      vec_t c;
      sb_t  s;
      sb_t  e;
      int   cnt;

`ifdef HAZARD_FWD_EN
      v("idle",      0,        0,  0,  0, 0, 0, NRM, NRM);
      v("add3",      ALU,      1,  2,  3, 0, 0, NRM, NRM);
      v("sub_rs3",   RD2,      3,  4, 10, 0, 0, TMP, NRM);
      v("prod5",     WR,       0,  0,  5, 0, 0, NRM, NRM);
      v("indep6",    ALU,      1,  2,  6, 0, 0, NRM, NRM);
      v("cons5",     RD2,      6,  5,  0, 0, 0, TMP, DAT);
      v("wr11a",     WR,       0,  0, 11, 0, 0, NRM, NRM);
      v("wr11b",     WR,       0,  0, 11, 0, 0, NRM, NRM);
      v("rd11_near", RD2,     11, 11,  0, 0, 0, TMP, TMP);
      v("rd11_ma",   F_V|F_URS,11,  0,  0, 0, 0, DAT, NRM);
      v("wr0",       WR,       0,  0,  0, 0, 0, NRM, NRM);
      v("rd0",       RD2,      0,  0,  0, 0, 0, NRM, NRM);
      v("wr12",      WR,       0,  0, 12, 0, 0, NRM, NRM);
      v("rd12_nouse",F_V,     12, 12,  0, 0, 0, NRM, NRM);
      v("lw4",       LW,       0,  0,  4, 0, 0, NRM, NRM);
      v("lu_stall",  ALU,      4,  1, 13, 1, 0, NRM, NRM);
      v("lu_issue",  ALU,      4,  1, 13, 0, 0, DAT, NRM);
      v("lw4b",      LW,       0,  0,  4, 0, 0, NRM, NRM);
      v("lu_flush",  ALU|F_FL, 4,  1, 13, 0, 0, NRM, NRM);
      v("lu_after",  ALU,      4,  1, 13, 0, 0, DAT, NRM);
      v("lw4c",      LW,       0,  0,  4, 0, 0, NRM, NRM);
      v("lu_noval",  ALU&~F_V, 4,  1, 13, 0, 0, NRM, NRM);
      v("idle",      0,        0,  0,  0, 0, 0, NRM, NRM);
`else
      v("idle",      0,        0,  0,  0, 0, 0, NRM, NRM);
      v("add3",      ALU,      1,  2,  3, 0, 0, NRM, NRM);
      v("sub_ex",    RD2,      3,  4, 10, 1, 0, NRM, NRM);
      v("sub_ma",    RD2,      3,  4, 10, 1, 0, NRM, NRM);
      v("sub_issue", RD2,      3,  4, 10, 0, 0, NRM, NRM);
      v("prod5",     WR,       0,  0,  5, 0, 0, NRM, NRM);
      v("indep6",    ALU,      1,  2,  6, 0, 0, NRM, NRM);
      v("cons_ex",   RD2,      6,  5,  0, 1, 0, NRM, NRM);
      v("cons_ma",   RD2,      6,  5,  0, 1, 0, NRM, NRM);
      v("cons_iss",  RD2,      6,  5,  0, 0, 0, NRM, NRM);
      v("wr11a",     WR,       0,  0, 11, 0, 0, NRM, NRM);
      v("wr11b",     WR,       0,  0, 11, 0, 0, NRM, NRM);
      v("rd11_ex",   RD2,     11, 11,  0, 1, 0, NRM, NRM);
      v("rd11_ma",   RD2,     11, 11,  0, 1, 0, NRM, NRM);
      v("rd11_iss",  RD2,     11, 11,  0, 0, 0, NRM, NRM);
      v("rd11_wb",   F_V|F_URS,11,  0,  0, 0, 0, NRM, NRM);
      v("wr0",       WR,       0,  0,  0, 0, 0, NRM, NRM);
      v("rd0",       RD2,      0,  0,  0, 0, 0, NRM, NRM);
      v("wr12",      WR,       0,  0, 12, 0, 0, NRM, NRM);
      v("rd12_nouse",F_V,     12, 12,  0, 0, 0, NRM, NRM);
      v("lw4",       LW,       0,  0,  4, 0, 0, NRM, NRM);
      v("lu_ex",     ALU,      4,  1, 13, 1, 0, NRM, NRM);
      v("lu_ma",     ALU,      4,  1, 13, 1, 0, NRM, NRM);
      v("lu_issue",  ALU,      4,  1, 13, 0, 0, NRM, NRM);
      v("lw4b",      LW,       0,  0,  4, 0, 0, NRM, NRM);
      v("lu_flush",  ALU|F_FL, 4,  1, 13, 0, 0, NRM, NRM);
      v("lu_ma2",    ALU,      4,  1, 13, 1, 0, NRM, NRM);
      v("lu_iss2",   ALU,      4,  1, 13, 0, 0, NRM, NRM);
      v("lw4c",      LW,       0,  0,  4, 0, 0, NRM, NRM);
      v("lu_noval",  ALU&~F_V, 4,  1, 13, 0, 0, NRM, NRM);
      v("idle",      0,        0,  0,  0, 0, 0, NRM, NRM);
`endif
      // Mul/div occupancy, flushed mult, combined load-use + md stall, reset mid-stall.
      v("mult",      MULT,     1,  2,  0, 0, 0, NRM, NRM);
      for (int i = 0; i < MD_LAT; i++)
         v("mflo_wait", MFLO,  0,  0,  8, 1, 1, NRM, NRM);
      v("mflo_iss",  MFLO,     0,  0,  8, 0, 0, NRM, NRM);
      v("mult_fl",   MULT|F_FL,1,  2,  0, 0, 0, NRM, NRM);
      v("idle_md0",  0,        0,  0,  0, 0, 0, NRM, NRM);
      v("mult2",     MULT,     1,  2,  0, 0, 0, NRM, NRM);
      v("lw9",       LW,       0,  0,  9, 0, 1, NRM, NRM);
      for (int i = 0; i < MD_LAT - 1; i++)
         v("mult9_st", F_V|F_MD|F_URS, 9, 0, 0, 1, 1, NRM, NRM);
      v("mult9_iss", F_V|F_MD|F_URS, 9, 0, 0, 0, 0, NRM, NRM);
      for (int i = 0; i < MD_LAT; i++)
         v("idle_busy", 0,     0,  0,  0, 0, 1, NRM, NRM);
      v("idle_free", 0,        0,  0,  0, 0, 0, NRM, NRM);
`ifdef HAZARD_FWD_EN
      v("lw4r",      LW,       0,  0,  4, 0, 0, NRM, NRM);
      v("lu_rst",    ALU|F_RST,4,  1, 13, 1, 0, NRM, NRM);
      v("lu_postrst",ALU,      4,  1, 13, 0, 0, NRM, NRM);
`else
      v("add3r",     ALU,      1,  2,  3, 0, 0, NRM, NRM);
      v("sub_rst",   RD2|F_RST,3,  4, 10, 1, 0, NRM, NRM);
      v("sub_postrst",RD2,     3,  4, 10, 0, 0, NRM, NRM);
`endif
      v("mult_r",    MULT,     1,  2,  0, 0, 0, NRM, NRM);
      v("mflo_rst",  MFLO|F_RST,0, 0,  8, 1, 1, NRM, NRM);
      v("mflo_post", MFLO,     0,  0,  8, 0, 0, NRM, NRM);

      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         c = vecs[i];
         @(negedge clk);
         drive(c.f, c.rs, c.rt, c.wreg);
         #1;
         chk(c.name, i, "stall_if_id", 32'(stall_if_id), 32'(c.e_stall));
         chk(c.name, i, "bubble_ex",   32'(bubble_ex),   32'(c.e_stall));
         chk(c.name, i, "md_busy",     32'(md_busy),     32'(c.e_busy));
         e.name = c.name; e.idx = i; e.a = c.e_a; e.b = c.e_b;
         sb.push_back(e);
         @(posedge clk);
         #1;
         s = sb.pop_front();
         chk(s.name, s.idx, "mux_fwd_rf_a", 32'(mux_fwd_rf_a), 32'(s.a));
         chk(s.name, s.idx, "mux_fwd_rf_b", 32'(mux_fwd_rf_b), 32'(s.b));
      end

      // Hand-written: mflo held in ID must wait exactly MD_LAT stalled cycles (bounded).
      @(negedge clk);
      drive(MULT, 5'd1, 5'd2, 5'd0);
      #1;
      chk("hs_mult", 0, "stall_if_id", 32'(stall_if_id), 32'(0));
      @(negedge clk);
      drive(MFLO, 5'd0, 5'd0, 5'd8);
      #1;
      cnt = 0;
      while (stall_if_id === 1'b1 && cnt < 20) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      chk("hs_mflo", 0, "stall_cycles", 32'(cnt), 32'(MD_LAT));
      chk("hs_mflo", 0, "md_busy", 32'(md_busy), 32'(0));
      @(negedge clk);
      drive(9'h000, 5'd0, 5'd0, 5'd0);
      #1;
      chk("hs_idle", 0, "md_busy", 32'(md_busy), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
